// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg: shared types and constants for the round-robin pulse scheduler.
package pulse_sched_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
    localparam logic DIR_UP = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first pending index at or above ptr (mod N).
module rr_pick #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          any
);
    always_comb begin
        winner = '0;
        // Scan downward so the lowest offset from ptr is written last and wins.
        for (int k = N - 1; k >= 0; k--)
            if (pending[(int'(ptr) + k) % N]) winner = N'(1) << ((int'(ptr) + k) % N);
    end
    assign any = |pending;
endmodule

// File: rtl/pulse_rr_sched.sv
// pulse_rr_sched: latches per-requester step pulses and applies them one at a time,
// in round-robin order, to a shared bounded up/down counter.
module pulse_rr_sched
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int CNT_WIDTH   = 7,
    parameter int MAX_VAL     = 99,
    parameter int WRAP        = 1,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [N_REQ-1:0]     pulse_in,
    input  logic [N_REQ-1:0]     dir_in,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic [N_REQ-1:0]     grant_onehot,
    output logic                 grant_valid,
    output logic                 bound_hit,
    output logic                 drop_err
);
    localparam int PW = $clog2(N_REQ);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] MAXV = CNT_WIDTH'(MAX_VAL);

    state_t state_q, state_d;
    logic [N_REQ-1:0] pend_q, pend_d, dir_q, dir_d, win_q, win_d, pick, clr, acc;
    logic [PW-1:0] ptr_q, ptr_d, win_idx;
    logic [HW-1:0] hold_q, hold_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic bound_q, bound_d, drop_q, drop_d, any, up, at_bound, granting;

    rr_pick #(.N(N_REQ)) u_pick (.pending(pend_q), .ptr(ptr_q), .winner(pick), .any(any));

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) if (win_q[i]) win_idx = PW'(i);
    end

    assign granting = state_q == GRANT;
    assign clr      = granting ? win_q : '0;
    // A pulse is accepted unless its slot is full and not being freed this edge.
    assign acc      = pulse_in & ~(pend_q & ~clr);
    assign up       = dir_q[win_idx] == DIR_UP;
    assign at_bound = up ? count_q == MAXV : count_q == '0;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        count_d = count_q;
        pend_d  = (pend_q & ~clr) | pulse_in;
        dir_d   = (dir_q & ~acc) | (dir_in & acc);
        drop_d  = drop_q | (|(pulse_in & ~acc));
        bound_d = granting & at_bound;
        if (state_q == IDLE && any) begin
            win_d   = pick;
            state_d = GRANT;
        end
        if (granting) begin
            count_d = at_bound ? ((WRAP != 0) ? (up ? '0 : MAXV) : count_q)
                               : (up ? count_q + 1'b1 : count_q - 1'b1);
            ptr_d   = win_idx == PW'(N_REQ - 1) ? '0 : win_idx + 1'b1;
            hold_d  = '0;
            state_d = (HOLD_CYCLES > 0) ? HOLD : IDLE;
        end
        if (state_q == HOLD) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            dir_q   <= '0;
            bound_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
            bound_q <= bound_d;
            drop_q  <= drop_d;
        end
    end

    assign count_out    = count_q;
    assign grant_onehot = clr;
    assign grant_valid  = granting;
    assign bound_hit    = bound_q;
    assign drop_err     = drop_q;
endmodule

// File: tb/tb_pulse_rr_sched.sv
// tb_pulse_rr_sched: scoreboard bench driving a wrapping and a saturating instance
// with identical pulses and checking grants, counts and flags against a model.
module tb_pulse_rr_sched;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic [3:0] pulse_in = '0, dir_in = '0;
    logic [6:0] cnt_w, cnt_s;
    logic [3:0] g_w, g_s;
    logic gv_w, gv_s, b_w, b_s, d_w, d_s;

    always #5 clk = ~clk;

    pulse_rr_sched #(.WRAP(1)) dut (
        .clk(clk), .resetN(resetN), .pulse_in(pulse_in), .dir_in(dir_in),
        .count_out(cnt_w), .grant_onehot(g_w), .grant_valid(gv_w),
        .bound_hit(b_w), .drop_err(d_w));

    pulse_rr_sched #(.WRAP(0)) dut_sat (
        .clk(clk), .resetN(resetN), .pulse_in(pulse_in), .dir_in(dir_in),
        .count_out(cnt_s), .grant_onehot(g_s), .grant_valid(gv_s),
        .bound_hit(b_s), .drop_err(d_s));

    typedef struct {
        logic [3:0] g;
        int cw;
        int cs;
        bit bw;
        bit bs;
        int gap;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit cnt_chk = 1'b0;
    int cyc = 0, last_g = 0, n_chk = 0, n_fail = 0, mw = 0, ms = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!resetN) cnt_chk = 1'b0;
        else begin
            if (cnt_chk) begin
                check("count_wrap", int'(cnt_w), cur.cw);
                check("count_sat", int'(cnt_s), cur.cs);
                check("bound_wrap", int'(b_w), int'(cur.bw));
                check("bound_sat", int'(b_s), int'(cur.bs));
                cnt_chk = 1'b0;
            end
            if (gv_w || gv_s) begin
                if (sb.size() == 0) check("unexpected_grant", int'({gv_w, gv_s}), 0);
                else begin
                    cur = sb.pop_front();
                    check("grant_wrap", int'(g_w), int'(cur.g));
                    check("grant_sat", int'(g_s), int'(cur.g));
                    check("gvalid_wrap", int'(gv_w), 1);
                    check("gvalid_sat", int'(gv_s), 1);
                    if (cur.gap != 0) check("grant_gap", cyc - last_g, cur.gap);
                    last_g  = cyc;
                    cnt_chk = 1'b1;
                end
            end
        end
    end

    task automatic push(input logic [3:0] g, input bit up, input int gap);
        exp_t e;
        e.g   = g;
        e.gap = gap;
        e.bw  = up ? (mw == 99) : (mw == 0);
        e.cw  = e.bw ? (up ? 0 : 99) : (up ? mw + 1 : mw - 1);
        e.bs  = up ? (ms == 99) : (ms == 0);
        e.cs  = e.bs ? ms : (up ? ms + 1 : ms - 1);
        mw = e.cw;
        ms = e.cs;
        sb.push_back(e);
    endtask

    task automatic pulse(input logic [3:0] m, input logic [3:0] d, input int n);
        @(posedge clk);
        #1 pulse_in = m;
        dir_in = d;
        repeat (n) @(posedge clk);
        #1 pulse_in = '0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((sb.size() != 0 || cnt_chk) && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (sb.size() != 0 || cnt_chk) begin
            check("timeout_pending", sb.size() + int'(cnt_chk), 0);
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_step(input logic [3:0] m, input bit up);
        push(m, up, 0);
        pulse(m, up ? m : 4'h0, 1);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
        check("rst_count", int'(cnt_w), 0);
        check("rst_gvalid", int'(gv_w), 0);
        check("rst_grant", int'(g_w), 0);
        check("rst_bound", int'(b_w), 0);
        check("rst_drop", int'(d_w), 0);

        // all four requesters at once, serviced 0..3 with HOLD spacing
        push(4'b0001, 1, 0);
        push(4'b0010, 1, 4);
        push(4'b0100, 1, 4);
        push(4'b1000, 1, 4);
        pulse(4'hf, 4'hf, 1);
        wait_idle();
        check("rr_final", int'(cnt_w), 4);

        // single step with cycle-exact latency
        push(4'b0001, 1, 0);
        pulse(4'b0001, 4'b0001, 1);
        @(negedge clk);
        check("gv_cycle_k", int'(gv_w), 0);
        @(negedge clk);
        check("gv_cycle_k1", int'(gv_w), 1);
        check("cnt_cycle_k1", int'(cnt_w), 4);
        wait_idle();

        // asynchronous reset in the middle of a GRANT
        push(4'b0010, 1, 0);
        pulse(4'b0010, 4'b0010, 1);
        @(negedge clk);
        @(negedge clk);
        check("gv_pre_rst", int'(gv_w), 1);
        check("cnt_pre_rst", int'(cnt_w), 5);
        #2 resetN = 1'b0;
        #1;
        check("async_count", int'(cnt_w), 0);
        check("async_count_sat", int'(cnt_s), 0);
        check("async_gvalid", int'(gv_w), 0);
        check("async_grant", int'(g_w), 0);
        check("async_bound", int'(b_w), 0);
        check("async_drop", int'(d_w), 0);
        repeat (2) @(negedge clk);
        #2 resetN = 1'b1;
        mw = 0;
        ms = 0;
        sb.delete();
        @(negedge clk);
        check("cnt_after_rst", int'(cnt_w), 0);
        repeat (6) @(negedge clk);

        // re-latch on the clearing edge, new direction taken
        push(4'b0010, 1, 0);
        push(4'b0010, 0, 4);
        pulse(4'b0010, 4'b0010, 1);
        @(posedge clk);
        #1 pulse_in = 4'b0010;
        dir_in = 4'b0000;
        @(posedge clk);
        #1 pulse_in = '0;
        wait_idle();
        check("relatch_nodrop", int'(d_w), 0);

        // requester 2 pulses twice while waiting behind a HOLD
        push(4'b0001, 1, 0);
        push(4'b0100, 1, 4);
        pulse(4'b0001, 4'b0001, 1);
        @(posedge clk);
        pulse(4'b0100, 4'b0100, 2);
        wait_idle();
        check("drop_set", int'(d_w), 1);
        check("drop_set_sat", int'(d_s), 1);
        check("drop_cnt", int'(cnt_w), 2);
        repeat (10) @(negedge clk);
        check("drop_sticky", int'(d_w), 1);

        resetN = 1'b0;
        #1 check("drop_cleared", int'(d_w), 0);
        repeat (2) @(negedge clk);
        #2 resetN = 1'b1;
        mw = 0;
        ms = 0;

        // bounds: climb to MAX_VAL, then step over each bound
        for (int i = 0; i < 99; i++) do_step(4'b0001, 1);
        check("at_max_wrap", int'(cnt_w), 99);
        check("at_max_sat", int'(cnt_s), 99);
        do_step(4'b0001, 1);
        do_step(4'b0001, 0);
        check("final_wrap", int'(cnt_w), 99);
        check("final_sat", int'(cnt_s), 98);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
